spy_serial_responder: RTL and testbench
=======================================

// Module: spy_serial_responder
// PURPOSE
//  Design-side end of the spy-over-serial link. Consumes command bytes from the UART
//  receiver, assembles a 16-bit data word, drives spy-bus reads/writes (eadr, dbread,
//  dbwrite, spy_out) and returns read data to the UART transmitter via tx_req/tx_ack.
//  Sits between the board UART and the CPU spy/debug register decode.
// PARAMETERS
//  READ_WAIT  2  cycles dbread is held before spy_in is sampled (legal 1..15)
// PORTS
//  clk        in   1   system clock; all logic on posedge
//  reset      in   1   asynchronous, active-low reset
//  rx_valid   in   1   one-cycle strobe: rx_data holds a received byte
//  rx_data    in   8   received command byte
//  tx_req     out  1   byte on tx_data is valid; held until tx_ack
//  tx_ack     in   1   transmitter accepted tx_data (sampled on posedge)
//  tx_data    out  8   response byte
//  eadr       out  5   spy register address
//  dbread     out  1   spy read strobe
//  dbwrite    out  1   spy write strobe (one cycle)
//  spy_out    out  16  write data to spy bus (= assembled data word)
//  spy_in     in   16  read data from spy bus
//  busy       out  1   command in progress; new bytes are dropped
//  overrun    out  1   sticky: a byte arrived while busy (cleared only by reset)
// BEHAVIOUR
//  Reset: all outputs 0; data word 0; state IDLE. Reset mid-operation aborts at once,
//   no partial strobe or byte completes.
//  Command bytes (high nibble op, low nibble n), decoded in IDLE on rx_valid:
//   0x3n/0x4n/0x5n/0x6n: load n into data[3:0]/[7:4]/[11:8]/[15:12]; stay IDLE.
//   0x8n: read eadr={0,n}; 0x9n: read eadr={1,n}.
//   0xAn: write eadr={0,n}; 0xBn: write eadr={1,n}.
//   Any other op: ignored, no state change, no overrun.
//  spy_out always reflects the data word; nibble loads take effect the cycle after strobe.
//  States: IDLE, RD, TXB, TXW, WR.
//   IDLE -rx read-> RD: eadr latched, dbread=1 for exactly READ_WAIT cycles; spy_in
//    captured on the last of them; then dbread=0 and -> TXB with byte index 0.
//   TXB: tx_data = {op_k, nibble_k} with k=0..3 -> 0x3,0x4,0x5,0x6 over spy_in
//    nibbles low to high; tx_req=1 -> TXW.
//   TXW: hold tx_req and tx_data stable until tx_ack sampled high; tx_req drops the
//    following cycle (minimum one low cycle between bytes); k<3 -> TXB, k==3 -> IDLE.
//   IDLE -rx write-> WR: eadr latched; dbwrite=1 for one cycle with eadr and spy_out
//    stable; -> IDLE next cycle. No response byte for writes.
//  Read response latency: first tx_req rises READ_WAIT+2 cycles after rx_valid.
//  busy=1 in every state except IDLE. rx_valid while busy: byte dropped, overrun<=1.
//  rx_valid in the same cycle the FSM returns to IDLE: treated as busy (dropped).
//  tx_ack while tx_req=0: ignored. dbread and dbwrite are never both high.
//  Data word is not modified by reads or writes; it persists across commands.
// TESTING
//  1. Reset, then bytes 0x34,0x43,0x52,0x61,0xA8 -> single dbwrite, eadr=0x08,
//     spy_out=0x1234; no tx_req; busy high exactly one cycle.
//  2. spy_in=0xBEEF, byte 0x91, tx_ack one cycle after each tx_req -> dbread held 2
//     cycles with eadr=0x11; tx bytes 0x3F,0x4E,0x5E,0x6B in order; back to IDLE.
//  3. Read with tx_ack withheld 50 cycles -> tx_req/tx_data stable 50 cycles, no
//     second byte until ack; tx_req low >=1 cycle between bytes.
//  4. Byte 0x80 then 0xA3 two cycles later -> 0xA3 dropped, no dbwrite, overrun=1 and
//     stays 1 after read completes; bytes 0x00,0x7F,0xC5 -> no bus activity, no overrun.
//  5. Assert reset during TXW after 2nd byte -> tx_req, dbread, busy 0 immediately;
//     after release, 0x80 produces a full 4-byte response.
//  6. READ_WAIT=1 build: 0x82 -> dbread exactly 1 cycle, first tx_req 3 cycles after
//     rx_valid.

Source files
------------

// File: rtl/spy_serial_responder.sv
// Spy-over-serial responder: turns UART command bytes into spy-bus reads and
// writes. Reads return four nibble-tagged bytes (0x3n..0x6n, low nibble first)
// through a req/ack handshake with the UART transmitter.
module spy_serial_responder #(
    parameter int READ_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_req,
    input  logic        tx_ack,
    output logic [7:0]  tx_data,
    output logic [4:0]  eadr,
    output logic        dbread,
    output logic        dbwrite,
    output logic [15:0] spy_out,
    input  logic [15:0] spy_in,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [2:0] {IDLE, RD, TXB, TXW, WR} state_t;

    localparam logic [3:0] RW_LAST = 4'(READ_WAIT - 1);

    state_t      r_state, w_next;
    logic [3:0]  r_cnt;
    logic [1:0]  r_idx;
    logic [15:0] r_rdata;
    logic [15:0] r_data;
    logic [7:0]  r_txd;
    logic [4:0]  r_eadr;
    logic        r_overrun;

    logic [3:0]  w_op, w_n, w_nib;
    logic        w_rd_cmd, w_wr_cmd, w_rd_last;

    assign w_op      = rx_data[7:4];
    assign w_n       = rx_data[3:0];
    assign w_rd_cmd  = rx_valid && (w_op == 4'h8 || w_op == 4'h9);
    assign w_wr_cmd  = rx_valid && (w_op == 4'hA || w_op == 4'hB);
    assign w_rd_last = (r_cnt == RW_LAST);

    assign tx_data   = r_txd;
    assign eadr      = r_eadr;
    assign spy_out   = r_data;
    assign overrun   = r_overrun;

    // State register; reset returns straight to IDLE, aborting any strobe or byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode and state-derived strobes.
    always_comb begin
        w_next  = r_state;
        tx_req  = 1'b0;
        dbread  = 1'b0;
        dbwrite = 1'b0;
        busy    = 1'b1;
        w_nib   = r_rdata[3:0];
        case (r_idx)
            2'd0: w_nib = r_rdata[3:0];
            2'd1: w_nib = r_rdata[7:4];
            2'd2: w_nib = r_rdata[11:8];
            2'd3: w_nib = r_rdata[15:12];
            default: w_nib = r_rdata[3:0];
        endcase
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_rd_cmd)      w_next = RD;
                else if (w_wr_cmd) w_next = WR;
            end
            RD: begin
                dbread = 1'b1;
                if (w_rd_last) w_next = TXB;
            end
            // One low-req cycle between bytes comes from passing through TXB.
            TXB: w_next = TXW;
            TXW: begin
                tx_req = 1'b1;
                if (tx_ack) w_next = (r_idx == 2'd3) ? IDLE : TXB;
            end
            WR: begin
                dbwrite = 1'b1;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Datapath: nibble loads, address latch, read wait count, capture and tx byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_rdata   <= '0;
            r_data    <= '0;
            r_txd     <= '0;
            r_eadr    <= '0;
            r_overrun <= 1'b0;
        end else begin
            // Any byte arriving outside IDLE is dropped, including the return cycle.
            if (rx_valid && r_state != IDLE) r_overrun <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (rx_valid) begin
                        case (w_op)
                            4'h3: r_data[3:0]   <= w_n;
                            4'h4: r_data[7:4]   <= w_n;
                            4'h5: r_data[11:8]  <= w_n;
                            4'h6: r_data[15:12] <= w_n;
                            4'h8, 4'h9, 4'hA, 4'hB: begin
                                r_eadr <= {w_op[0], w_n};
                                r_cnt  <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                RD: begin
                    if (w_rd_last) begin
                        r_rdata <= spy_in;
                        r_idx   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                TXB: r_txd <= {4'd3 + {2'b00, r_idx}, w_nib};
                TXW: if (tx_ack) r_idx <= r_idx + 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spy_serial_responder.sv
// Bench for spy_serial_responder: scoreboard of expected response bytes,
// bus-activity monitor on the falling edge, and a programmable tx_ack responder.
module tb_spy_serial_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_valid = 1'b0, rx_valid1 = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_ack = 1'b0;
    logic [15:0] spy_in = 16'h0000;

    logic        tx_req, dbread, dbwrite, busy, overrun;
    logic [7:0]  tx_data;
    logic [4:0]  eadr;
    logic [15:0] spy_out;

    logic        tx_req1, dbread1, dbwrite1, busy1, overrun1;
    logic [7:0]  tx_data1;
    logic [4:0]  eadr1;
    logic [15:0] spy_out1;
    wire         tx_ack1;

    assign tx_ack1 = tx_req1;

    spy_serial_responder #(.READ_WAIT(2)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_req(tx_req), .tx_ack(tx_ack), .tx_data(tx_data), .eadr(eadr),
        .dbread(dbread), .dbwrite(dbwrite), .spy_out(spy_out), .spy_in(spy_in),
        .busy(busy), .overrun(overrun)
    );

    spy_serial_responder #(.READ_WAIT(1)) dut1 (
        .clk(clk), .reset(reset), .rx_valid(rx_valid1), .rx_data(rx_data),
        .tx_req(tx_req1), .tx_ack(tx_ack1), .tx_data(tx_data1), .eadr(eadr1),
        .dbread(dbread1), .dbwrite(dbwrite1), .spy_out(spy_out1), .spy_in(spy_in),
        .busy(busy1), .overrun(overrun1)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    logic [7:0] exp_q[$];

    int rd_run = 0, rd_last = 0, rd_tot = 0, wr_cnt = 0, busy_cnt = 0;
    int req_run = 0, req_last = 0, tx_cnt = 0, rd1_cnt = 0;
    logic [4:0]  rd_eadr = 5'h0, wr_eadr = 5'h0;
    logic [15:0] wr_data = 16'h0;
    logic        prev_acked = 1'b0;
    int ack_dly = 0, ack_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step(1);
        rx_valid = 1'b0;
    endtask

    task automatic push_rd(input logic [15:0] v);
        exp_q.push_back({4'h3, v[3:0]});
        exp_q.push_back({4'h4, v[7:4]});
        exp_q.push_back({4'h5, v[11:8]});
        exp_q.push_back({4'h6, v[15:12]});
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 2000) begin
            step(1);
            n++;
        end
        if (n >= 2000) chk("idle_timeout", 1, 0);
        step(2);
    endtask

    task automatic lat0(output int k);
        k = 1;
        while (!tx_req && k < 20) begin
            step(1);
            k++;
        end
    endtask

    // Falling-edge monitor: bus strobes, busy, and tx bytes against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            if (dbread) begin
                rd_run++;
                rd_tot++;
                rd_eadr = eadr;
            end else if (rd_run > 0) begin
                rd_last = rd_run;
                rd_run  = 0;
            end
            if (dbwrite) begin
                wr_cnt++;
                wr_eadr = eadr;
                wr_data = spy_out;
            end
            if (dbread && dbwrite)   chk("rdwr_excl", 1, 0);
            if (dbread1 && dbwrite1) chk("rdwr_excl1", 1, 0);
            if (dbread1) rd1_cnt++;
            if (busy) busy_cnt++;
            if (tx_req) begin
                req_run++;
                if (prev_acked) chk("tx_gap", 1, 0);
                if (exp_q.size() == 0) chk("tx_unexpected", 1, 0);
                else                   chk("tx_data", tx_data, exp_q[0]);
                if (tx_ack) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    tx_cnt++;
                end
            end else if (req_run > 0) begin
                req_last = req_run;
                req_run  = 0;
            end
            prev_acked = tx_req && tx_ack;
        end
    end

    // Transmitter model: acks a held tx_req after ack_dly extra cycles, one-cycle pulse.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            tx_ack  = 1'b0;
            ack_cnt = 0;
        end else if (tx_ack) begin
            tx_ack = 1'b0;
        end else if (tx_req) begin
            if (ack_cnt >= ack_dly) begin
                tx_ack  = 1'b1;
                ack_cnt = 0;
            end else begin
                ack_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, wr0, rd0, tx0, n;

        step(3);
        chk("rst_tx_req", tx_req, 0);
        chk("rst_dbread", dbread, 0);
        chk("rst_dbwrite", dbwrite, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_spy_out", spy_out, 16'h0);
        chk("rst_eadr", eadr, 5'h0);
        chk("rst_tx_data", tx_data, 8'h0);
        reset = 1'b1;
        step(2);

        // 1: nibble loads then write
        send(8'h34); send(8'h43); send(8'h52); send(8'h61);
        chk("t1_spy_out", spy_out, 16'h1234);
        wr0 = wr_cnt; tx0 = tx_cnt; busy_cnt = 0;
        send(8'hA8);
        step(3);
        chk("t1_wr_cnt", wr_cnt - wr0, 1);
        chk("t1_wr_eadr", wr_eadr, 5'h08);
        chk("t1_wr_data", wr_data, 16'h1234);
        chk("t1_busy_cycles", busy_cnt, 1);
        chk("t1_no_tx", tx_cnt - tx0, 0);
        chk("t1_overrun", overrun, 0);

        // 2: read 0x11 with ack one cycle after req
        ack_dly = 1;
        spy_in  = 16'hBEEF;
        push_rd(spy_in);
        tx0 = tx_cnt;
        send(8'h91);
        lat0(k);
        chk("t2_latency", k, 4);
        wait_idle();
        chk("t2_rd_len", rd_last, 2);
        chk("t2_rd_eadr", rd_eadr, 5'h11);
        chk("t2_tx_cnt", tx_cnt - tx0, 4);
        chk("t2_req_hold", req_last, 2);
        chk("t2_q_empty", exp_q.size(), 0);
        chk("t2_busy", busy, 0);
        chk("t2_data_kept", spy_out, 16'h1234);

        // 3: ack withheld 50 cycles per byte
        ack_dly = 50;
        spy_in  = 16'h5A3C;
        push_rd(spy_in);
        tx0 = tx_cnt;
        send(8'h8F);
        wait_idle();
        chk("t3_req_hold", req_last, 51);
        chk("t3_tx_cnt", tx_cnt - tx0, 4);
        chk("t3_q_empty", exp_q.size(), 0);

        // 4a: undefined ops are ignored
        wr0 = wr_cnt; rd0 = rd_tot; tx0 = tx_cnt; busy_cnt = 0;
        send(8'h00); send(8'h7F); send(8'hC5);
        step(3);
        chk("t4_ign_wr", wr_cnt - wr0, 0);
        chk("t4_ign_rd", rd_tot - rd0, 0);
        chk("t4_ign_tx", tx_cnt - tx0, 0);
        chk("t4_ign_busy", busy_cnt, 0);
        chk("t4_ign_overrun", overrun, 0);
        chk("t4_ign_data", spy_out, 16'h1234);

        // 4b: write arriving during a read is dropped and flags overrun
        ack_dly = 0;
        spy_in  = 16'h0F0F;
        push_rd(spy_in);
        wr0 = wr_cnt;
        send(8'h80);
        step(1);
        send(8'hA3);
        chk("t4_overrun_set", overrun, 1);
        wait_idle();
        chk("t4_no_write", wr_cnt - wr0, 0);
        chk("t4_overrun_sticky", overrun, 1);
        chk("t4_rd_eadr", rd_eadr, 5'h00);
        chk("t4_q_empty", exp_q.size(), 0);

        // 5: reset during the third byte's handshake
        ack_dly = 1;
        spy_in  = 16'h1357;
        push_rd(spy_in);
        tx0 = tx_cnt;
        send(8'h80);
        n = 0;
        while (!((tx_cnt - tx0) == 2 && tx_req) && n < 100) begin
            step(1);
            n++;
        end
        chk("t5_reach_txw", n < 100, 1);
        reset = 1'b0;
        #1;
        chk("t5_rst_tx_req", tx_req, 0);
        chk("t5_rst_dbread", dbread, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_overrun", overrun, 0);
        chk("t5_rst_spy_out", spy_out, 16'h0);
        exp_q.delete();
        step(2);
        reset = 1'b1;
        step(1);
        spy_in = 16'h9ABC;
        push_rd(spy_in);
        tx0 = tx_cnt;
        send(8'h80);
        wait_idle();
        chk("t5_tx_cnt", tx_cnt - tx0, 4);
        chk("t5_q_empty", exp_q.size(), 0);

        // 6: READ_WAIT=1 instance
        spy_in   = 16'h00C4;
        rd1_cnt  = 0;
        rx_data  = 8'h82;
        rx_valid1 = 1'b1;
        step(1);
        rx_valid1 = 1'b0;
        k = 1;
        while (!tx_req1 && k < 20) begin
            step(1);
            k++;
        end
        chk("t6_latency", k, 3);
        chk("t6_first_byte", tx_data1, 8'h34);
        n = 0;
        while (busy1 && n < 100) begin
            step(1);
            n++;
        end
        chk("t6_idle", busy1, 0);
        step(1);
        chk("t6_rd_len", rd1_cnt, 1);
        chk("t6_eadr", eadr1, 5'h02);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
